// File: rtl/sat_decim_accum_if.sv
// Stream bundle for sat_decim_accum: sample input and frame-sum output
// handshakes. The DUT uses the slave modport, the driving side uses master.
interface sat_decim_accum_if #(
    parameter int IWIDTH = 16,
    parameter int OWIDTH = 20
);
    logic [IWIDTH-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [OWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/sat_decim_accum.sv
// Saturating integrate-and-dump decimator with single-entry output register.
// Optional sticky overflow flag is built when SAT_DECIM_OVF_EN is defined.
module sat_decim_accum #(
    parameter int IWIDTH = 16,
    parameter int OWIDTH = 20,
    parameter int CWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sat_decim_accum_if.slave  bus,
    input  logic [CWIDTH-1:0] n_decim,
    output logic              ovf,
    input  logic              ovf_clear
);
    localparam logic [OWIDTH:0] SUM_MAX = {2'b00, {(OWIDTH-1){1'b1}}};
    localparam logic [OWIDTH:0] SUM_MIN = {2'b11, {(OWIDTH-1){1'b0}}};

    logic [OWIDTH-1:0] acc_q, acc_d;
    logic [CWIDTH-1:0] cnt_q, cnt_d;
    logic [CWIDTH-1:0] n_cur_q, n_cur_d;
    logic [OWIDTH-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic              accept;
    logic              final_acc;
    logic              clamp;
    logic [OWIDTH:0]   in_ext;
    logic [OWIDTH:0]   sum_w;
    logic [OWIDTH-1:0] sum_sat;
    logic [CWIDTH-1:0] n_sel;
    logic [CWIDTH-1:0] n_eff;
    logic [CWIDTH:0]   cnt_inc;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign accept        = bus.in_valid && bus.in_ready;

    // The frame length is taken live from n_decim on the first sample of a
    // frame, so the final-sample decision uses it before n_cur_q is loaded.
    always_comb begin
        n_sel     = (cnt_q == '0) ? n_decim : n_cur_q;
        n_eff     = (n_sel == '0) ? CWIDTH'(1) : n_sel;
        cnt_inc   = {1'b0, cnt_q} + (CWIDTH+1)'(1);
        final_acc = (cnt_inc >= {1'b0, n_eff});
    end

    always_comb begin
        in_ext = {{(OWIDTH+1-IWIDTH){bus.in_data[IWIDTH-1]}}, bus.in_data};
        sum_w  = {acc_q[OWIDTH-1], acc_q} + in_ext;
        clamp  = (sum_w[OWIDTH] != sum_w[OWIDTH-1]);
        if (!clamp) begin
            sum_sat = sum_w[OWIDTH-1:0];
        end else if (sum_w[OWIDTH]) begin
            sum_sat = SUM_MIN[OWIDTH-1:0];
        end else begin
            sum_sat = SUM_MAX[OWIDTH-1:0];
        end
    end

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        n_cur_d     = n_cur_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            if (cnt_q == '0) begin
                n_cur_d = n_decim;
            end
            if (final_acc) begin
                out_data_d  = sum_sat;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d = sum_sat;
                cnt_d = cnt_inc[CWIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            n_cur_q     <= CWIDTH'(1);
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            n_cur_q     <= n_cur_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef SAT_DECIM_OVF_EN
    logic ovf_q, ovf_d;

    // Set has priority over clear on the same edge.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clear) begin
            ovf_d = 1'b0;
        end
        if (accept && clamp) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clear;
    assign unused_ovf_clear = ovf_clear;
    assign ovf = 1'b0;
`endif
endmodule
